// File: rtl/color_pkg.sv
// Shared definitions for the colour sensor emulator and the colour classifier.
//   Filter codes match the s2/s3 pin encoding of a TCS3200-style sensor.
//   Scale codes match the s0/s1 pin encoding; scale_factor() turns a scale code
//   into the half-period multiplier (a lower output frequency means a longer half-period).
package color_pkg;

   localparam logic [1:0] FLT_RED   = 2'b00;
   localparam logic [1:0] FLT_BLUE  = 2'b01;
   localparam logic [1:0] FLT_CLEAR = 2'b10;
   localparam logic [1:0] FLT_GREEN = 2'b11;

   localparam logic [1:0] SCL_OFF  = 2'b00;  // power-down
   localparam logic [1:0] SCL_2PC  = 2'b01;  // 2% output frequency
   localparam logic [1:0] SCL_20PC = 2'b10;  // 20% output frequency
   localparam logic [1:0] SCL_FULL = 2'b11;  // 100% output frequency

   typedef enum logic [1:0] {
      StOff,
      StLoad,
      StRun
   } gen_state_e;

   function automatic logic [5:0] scale_factor(input logic [1:0] scl);
      logic [5:0] f;
      case (scl)
         SCL_2PC:  f = 6'd50;
         SCL_20PC: f = 6'd5;
         SCL_FULL: f = 6'd1;
         default:  f = 6'd0;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
//   clk : destination clock
//   rst : asynchronous active-low reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output, two clk edges after first sampling
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/color_sensor_emu.sv
// TCS3200-style colour sensor emulator: drives a square wave whose half-period is
// hp[filter] * scale_factor clk cycles, with per-filter half-periods programmable at runtime.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   s0, s1    : scaling select pins (async)
//   s2, s3    : filter select pins (async)
//   cfg_wr    : one-cycle write strobe for hp[cfg_sel] <= cfg_hp
//   cfg_sel   : filter code being written
//   cfg_hp    : half-period value being written
//   signal    : emulated sensor frequency output
//   active_ch : synchronized filter code
//   busy      : high while a tone is being generated
module color_sensor_emu
   import color_pkg::*;
#(
   parameter int unsigned HPW      = 20,
   parameter int unsigned RED_HP   = 5000,
   parameter int unsigned BLUE_HP  = 8000,
   parameter int unsigned GREEN_HP = 10000,
   parameter int unsigned CLEAR_HP = 2500
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           s2,
   input  logic           s3,
   input  logic           s0,
   input  logic           s1,
   input  logic           cfg_wr,
   input  logic [1:0]     cfg_sel,
   input  logic [HPW-1:0] cfg_hp,
   output logic           signal,
   output logic [1:0]     active_ch,
   output logic           busy
);

   localparam int unsigned EffW = HPW + 6;

   logic s0_sync, s1_sync, s2_sync, s3_sync;

   sync2 u_sync_s0 (.clk(clk), .rst(rst), .d(s0), .q(s0_sync));
   sync2 u_sync_s1 (.clk(clk), .rst(rst), .d(s1), .q(s1_sync));
   sync2 u_sync_s2 (.clk(clk), .rst(rst), .d(s2), .q(s2_sync));
   sync2 u_sync_s3 (.clk(clk), .rst(rst), .d(s3), .q(s3_sync));

   logic [1:0] scale;
   assign active_ch = {s2_sync, s3_sync};
   assign scale     = {s0_sync, s1_sync};

   // Per-filter half-period registers, indexed by filter code.
   logic [HPW-1:0] hp_q [4];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hp_q[FLT_RED]   <= HPW'(RED_HP);
         hp_q[FLT_BLUE]  <= HPW'(BLUE_HP);
         hp_q[FLT_CLEAR] <= HPW'(CLEAR_HP);
         hp_q[FLT_GREEN] <= HPW'(GREEN_HP);
      end else if (cfg_wr) begin
         hp_q[cfg_sel] <= cfg_hp;
      end
   end

   logic [HPW-1:0]  hp_sel;
   logic [EffW-1:0] eff_hp;
   logic            off_cond;
   logic [1:0]      sel_prev_q, scl_prev_q;
   logic            change;

   assign hp_sel   = hp_q[active_ch];
   assign eff_hp   = EffW'(hp_sel) * EffW'(scale_factor(scale));
   assign off_cond = (scale == SCL_OFF) || (hp_sel == '0);
   assign change   = (active_ch != sel_prev_q) || (scale != scl_prev_q);

   gen_state_e      state_q, state_d;
   logic            sig_q, sig_d;
   logic [EffW-1:0] cnt_q, cnt_d;
   logic [EffW-1:0] eff_q, eff_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StOff;
         sig_q      <= 1'b0;
         cnt_q      <= '0;
         eff_q      <= '0;
         sel_prev_q <= 2'b00;
         scl_prev_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         sig_q      <= sig_d;
         cnt_q      <= cnt_d;
         eff_q      <= eff_d;
         sel_prev_q <= active_ch;
         scl_prev_q <= scale;
      end
   end

   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      eff_d   = eff_q;
      case (state_q)
         StOff: begin
            sig_d = 1'b0;
            cnt_d = '0;
            if (!off_cond) state_d = StLoad;
         end
         StLoad: begin
            if (off_cond) begin
               state_d = StOff;
               sig_d   = 1'b0;
            end else begin
               eff_d   = eff_hp;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (change) begin
               // New filter/scale: restart the count, holding the output level.
               if (off_cond) begin
                  state_d = StOff;
                  sig_d   = 1'b0;
                  cnt_d   = '0;
               end else begin
                  state_d = StLoad;
               end
            end else if (cnt_q == eff_q - EffW'(1)) begin
               // Half-period boundary: pick up any hp write made during this half-period.
               cnt_d = '0;
               eff_d = eff_hp;
               if (off_cond) begin
                  state_d = StOff;
                  sig_d   = 1'b0;
               end else begin
                  sig_d = ~sig_q;
               end
            end else begin
               cnt_d = cnt_q + EffW'(1);
            end
         end
         default: begin
            state_d = StOff;
            sig_d   = 1'b0;
         end
      endcase
   end

   assign signal = sig_q;
   assign busy   = (state_q != StOff);

endmodule

// File: tb/tb_color_sensor_emu.sv
// Directed bench for color_sensor_emu. Reset half-periods are scaled down
// (red 50, blue 80, green 100, clear 25) to keep the run short.
module tb_color_sensor_emu;

   localparam int unsigned HPW = 20;

   logic           clk = 1'b0;
   logic           rst;
   logic           s0, s1, s2, s3;
   logic           cfg_wr;
   logic [1:0]     cfg_sel;
   logic [HPW-1:0] cfg_hp;
   logic           signal;
   logic [1:0]     active_ch;
   logic           busy;

   int unsigned total  = 0;
   int unsigned passed = 0;
   int unsigned n;

   color_sensor_emu #(
      .HPW     (HPW),
      .RED_HP  (50),
      .BLUE_HP (80),
      .GREEN_HP(100),
      .CLEAR_HP(25)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s2       (s2),
      .s3       (s3),
      .s0       (s0),
      .s1       (s1),
      .cfg_wr   (cfg_wr),
      .cfg_sel  (cfg_sel),
      .cfg_hp   (cfg_hp),
      .signal   (signal),
      .active_ch(active_ch),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick(input int unsigned k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Edges until signal changes level; 0 if it never does within max.
   task automatic wait_toggle(input int unsigned max, output int unsigned cnt);
      logic lvl;
      lvl = signal;
      cnt = 0;
      do begin
         @(posedge clk);
         #1;
         cnt++;
      end while (signal === lvl && cnt < max);
      if (signal === lvl) cnt = 0;
   endtask

   task automatic write_hp(input logic [1:0] sel, input logic [HPW-1:0] val);
      cfg_sel = sel;
      cfg_hp  = val;
      cfg_wr  = 1'b1;
      tick(1);
      cfg_wr  = 1'b0;
   endtask

   initial begin
      rst = 1'b0; s0 = 1'b1; s1 = 1'b1; s2 = 1'b0; s3 = 1'b0;
      cfg_wr = 1'b0; cfg_sel = 2'b00; cfg_hp = '0;
      tick(3);
      check("rst_signal", int'(signal), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_active_ch", int'(active_ch), 0);

      // Red at x1: 2 sync + LOAD, then 50-cycle half-periods.
      @(negedge clk);
      rst = 1'b1;
      wait_toggle(200, n);
      check("red_first_toggle", n, 54);
      check("red_busy", int'(busy), 1);
      check("red_active_ch", int'(active_ch), 0);
      wait_toggle(200, n);
      check("red_half_1", n, 50);
      wait_toggle(200, n);
      check("red_half_2", n, 50);

      // Switch to green mid half-period; level held until new tone's first toggle.
      tick(10);
      s2 = 1'b1; s3 = 1'b1;
      tick(1);
      check("green_ach_1cyc", int'(active_ch), 0);
      tick(1);
      check("green_ach_2cyc", int'(active_ch), 3);
      wait_toggle(300, n);
      check("green_first_toggle", n + 2, 104);
      wait_toggle(300, n);
      check("green_half_1", n, 100);
      wait_toggle(300, n);
      check("green_half_2", n, 100);

      // Blue at x5 (20%): 80 * 5 = 400.
      s0 = 1'b1; s1 = 1'b0; s2 = 1'b0; s3 = 1'b1;
      tick(2);
      check("blue_ach", int'(active_ch), 1);
      wait_toggle(600, n);
      check("blue_first_toggle", n + 2, 404);
      wait_toggle(600, n);
      check("blue_half_1", n, 400);
      wait_toggle(600, n);
      check("blue_half_2", n, 400);

      // Power-down while signal is high.
      s0 = 1'b0; s1 = 1'b0;
      tick(3);
      check("pd_signal", int'(signal), 0);
      check("pd_busy", int'(busy), 0);

      // Back to red x1, then reprogram red to 10 right after a toggle.
      s0 = 1'b1; s1 = 1'b1; s2 = 1'b0; s3 = 1'b0;
      wait_toggle(200, n);
      check("red2_first_toggle", n, 54);
      write_hp(2'b00, 20'd10);
      wait_toggle(200, n);
      check("cfg_no_shorten", n + 1, 50);
      wait_toggle(200, n);
      check("cfg_new_half_1", n, 10);
      wait_toggle(200, n);
      check("cfg_new_half_2", n, 10);

      // Zero the active channel while signal is low: OFF at the next boundary, held low.
      write_hp(2'b00, 20'd0);
      tick(8);
      check("zero_busy_before", int'(busy), 1);
      tick(1);
      check("zero_busy_at_toggle", int'(busy), 0);
      check("zero_signal_at_toggle", int'(signal), 0);
      tick(5);
      check("zero_signal_hold", int'(signal), 0);
      check("zero_busy_hold", int'(busy), 0);

      // Reprogram to 20 from OFF.
      write_hp(2'b00, 20'd20);
      wait_toggle(200, n);
      check("hp20_first_toggle", n + 1, 23);
      wait_toggle(200, n);
      check("hp20_half_1", n, 20);
      wait_toggle(200, n);
      check("hp20_half_2", n, 20);

      // Async reset mid-RUN while signal is high; hp must return to 50.
      tick(5);
      #2;
      rst = 1'b0;
      #1;
      check("midrst_signal", int'(signal), 0);
      check("midrst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b1;
      wait_toggle(200, n);
      check("post_rst_first_toggle", n, 54);
      wait_toggle(200, n);
      check("post_rst_half", n, 50);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
